// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative integer / M-extension ALU.
// Opcodes, FSM encoding and width-derived constants.
package iter_alu_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLL    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  localparam int MAX_W = 64;

  // Returned at MAX_W bits; callers truncate to their own WIDTH.
  function automatic logic [MAX_W-1:0] most_neg(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] all_ones(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/alu_simple.sv
// Combinational evaluator for the single-cycle RV32I/RV64I ALU ops.
// Unlisted opcodes evaluate to zero.
module alu_simple
  import iter_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       ctrl_i,
  output logic [WIDTH-1:0] y_o
);

  logic [SHAMT_W-1:0] shamt;
  logic               slt;
  logic               sltu;

  assign shamt = b_i[SHAMT_W-1:0];
  assign slt   = $signed(a_i) < $signed(b_i);
  assign sltu  = a_i < b_i;

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, slt};
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $signed(a_i) >>> shamt;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, sltu};
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle execute-stage ALU: simple ops in one cycle, MUL/DIV
// iterate one bit per cycle over a shared 2*WIDTH shift register.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));
  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 zero_q, zero_d;
  logic [4:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] simple_y;

  alu_simple #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_simple (
    .a_i    (a),
    .b_i    (b),
    .ctrl_i (alu_ctrl),
    .y_o    (simple_y)
  );

  // Request decode, only meaningful on the accept edge.
  logic             is_mul, is_div, is_quot;
  logic             a_sgn, b_sgn, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul  = alu_ctrl >= ALU_MUL && alu_ctrl <= ALU_MULHU;
  assign is_div  = alu_ctrl >= ALU_DIV && alu_ctrl <= ALU_REMU;
  assign is_quot = alu_ctrl == ALU_DIV || alu_ctrl == ALU_DIVU;
  assign a_sgn   = a[WIDTH-1] &
                   (alu_ctrl == ALU_MULH || alu_ctrl == ALU_MULHSU ||
                    alu_ctrl == ALU_DIV  || alu_ctrl == ALU_REM);
  assign b_sgn   = b[WIDTH-1] &
                   (alu_ctrl == ALU_MULH || alu_ctrl == ALU_DIV ||
                    alu_ctrl == ALU_REM);
  assign a_mag   = a_sgn ? -a : a;
  assign b_mag   = b_sgn ? -b : b;
  assign div_ovf = (alu_ctrl == ALU_DIV || alu_ctrl == ALU_REM) &&
                   a == MOST_NEG && b == ALL_ONES;

  // One shift-add step: acc holds {partial product, remaining multiplier}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx, prod;
  logic [WIDTH-1:0]   mul_res;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod    = neg_q ? -mul_nx : mul_nx;
  assign mul_res = op_q == ALU_MUL ? prod[WIDTH-1:0]
                                   : prod[2*WIDTH-1:WIDTH];

  // One restoring step: acc holds {partial remainder, dividend/quotient}.
  logic [WIDTH:0]     div_try;
  logic [2*WIDTH-1:0] div_nx;
  logic [WIDTH-1:0]   quo, rem, div_res;

  assign div_try = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_nx  = div_try[WIDTH]
                 ? {acc_q[2*WIDTH-2:0], 1'b0}
                 : {div_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo     = div_nx[WIDTH-1:0];
  assign rem     = div_nx[2*WIDTH-1:WIDTH];
  assign div_res = (op_q == ALU_DIV || op_q == ALU_DIVU)
                 ? (neg_q ? -quo : quo)
                 : (neg_q ? -rem : rem);

  logic             wr;
  logic [WIDTH-1:0] wr_val;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    wr      = 1'b0;
    wr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = alu_ctrl;
          cnt_d = '0;
          if (is_mul) begin
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            opnd_d  = a_mag;
            neg_d   = a_sgn ^ b_sgn;
            state_d = ST_MUL;
          end else if (is_div && b == '0) begin
            wr      = 1'b1;
            wr_val  = is_quot ? ALL_ONES : a;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            wr      = 1'b1;
            wr_val  = is_quot ? a : '0;
            state_d = ST_DONE;
          end else if (is_div) begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opnd_d  = b_mag;
            neg_d   = is_quot ? (a_sgn ^ b_sgn) : a_sgn;
            state_d = ST_DIV;
          end else begin
            wr      = 1'b1;
            wr_val  = simple_y;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_nx;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == LAST) begin
          wr      = 1'b1;
          wr_val  = mul_res;
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        acc_d = div_nx;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == LAST) begin
          wr      = 1'b1;
          wr_val  = div_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    res_d  = wr ? wr_val : res_q;
    zero_d = wr ? (wr_val == '0) : zero_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign busy      = state_q == ST_MUL || state_q == ST_DIV;
  assign alu_out   = res_q;
  assign zero      = zero_q;

endmodule
